uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- Serial transmit side of the team's 8-bit UART, paired with the existing receiver.
- Accepts one byte per valid/ready handshake and shifts it out on o_tx as start bit, 8 data bits LSB first, optional parity, then stop bit(s).
- Bit timing uses the same fractional-accumulator baud scheme as the receiver, with OVERSAMPLE ticks per bit, so both ends share baud settings.

Parameters:
- BIT_DEPTH, 11, width of the baud phase accumulator; a tick fires on its carry-out.
- ADDER, 170, accumulator increment; tick rate = f_clk*ADDER/2^BIT_DEPTH. Legal range 1..2^BIT_DEPTH.
- OVERSAMPLE, 16, baud ticks per serial bit. Must match the receiver's full_baud.
- STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_8_data  input  8  byte to send; sampled only on accept.
- i_data_valid  input  1  byte on i_8_data is valid.
- o_ready  output  1  block can accept a byte this cycle.
- o_tx  output  1  serial line; idles high.
- o_done  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, o_tx=1, o_ready=1, o_done=0, accumulator=0, tick counter=0, bit index=0, shift register=0. Takes effect immediately, including mid-frame; o_tx returns high with no partial frame completion.
- Accept: at a rising edge where o_ready=1 and i_data_valid=1, latch i_8_data, clear accumulator and tick counter, and enter START. o_ready is 0 from the next cycle. i_data_valid is ignored while o_ready=0.
- Baud tick: each cycle, {carry,acc} = acc + ADDER (BIT_DEPTH+1 bits); tick = carry. The accumulator runs only outside IDLE. Clearing it on accept makes every bit exactly OVERSAMPLE ticks long.
- Tick counter: 0..OVERSAMPLE-1. On the tick where the counter equals OVERSAMPLE-1, it wraps to 0 and the bit period ends.
- FSM (o_tx is registered):
  - IDLE: o_tx=1.
  - START: o_tx=0 for one bit period, then DATA with index=0.
  - DATA: o_tx=shift[0]. At end of bit, shift right; index++. After index 7, go to PARITY if enabled, else STOP.
  - PARITY: see Optional Feature.
  - STOP: o_tx=1 for STOP_BITS bit periods, then IDLE with o_done=1 for that one cycle.
- Latency: o_tx falls on the first edge after accept. 8N1 frame length = 10*OVERSAMPLE ticks.
- o_ready is 1 in IDLE only. Back-to-back bytes: at least one IDLE cycle, with o_tx=1, between the last stop bit and the next start bit.
- Simultaneous reset deassertion and valid: a byte is accepted on the first edge after reset is released.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA, driving o_tx = XOR of the 8 latched bits (even parity) for one bit period. Frame = 11 bits + extra stop.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

Decomposition:
- Shared package: FSM state encodings (IDLE, START, DATA, PARITY, STOP), START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1, default BIT_DEPTH/ADDER/OVERSAMPLE. The receiver imports the same package.
- Sub-module uart_baud_tick: accumulator with synchronous clear and enable inputs, one-cycle tick output, parameterised BIT_DEPTH/ADDER. Reusable by the receiver.

Test Plan:
- All tests use BIT_DEPTH=11, ADDER=1024, OVERSAMPLE=16, so there is a tick every 2 clocks and a bit lasts 32 clocks.
- Reset: hold i_reset=0, then release -> o_tx=1, o_ready=1, o_done=0; no transitions for 500 clocks.
- Single byte 0xA5: o_tx falls 1 clock after accept. Sampled at bit centres it reads 0,1,0,1,0,0,1,0,1,1. o_done pulses 320 clocks after accept. o_ready is back at 1 on the same cycle.
- Back-to-back 0x00 then 0xFF with i_data_valid held high: second accept occurs the cycle o_ready returns. Exactly one idle-high cycle between frames. Second frame reads 0,1×8,1.
- Reset mid-frame: assert i_reset at bit 4 of 0x3C -> o_tx=1 asynchronously, o_ready=1. A following 0x81 transmits correctly.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1; send 0x03 -> parity bit 0. Frame is 11 bits = 352 clocks to o_done.
- Loopback into uart_receiver with default parameters: 256 random bytes received equal to bytes sent.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encodings, line levels, default baud settings.
// Latency: n/a (types, constants and a parity helper only).
// Backpressure: n/a; imported by both the transmitter and the receiver.
package uart_transmitter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam int DEFAULT_BIT_DEPTH  = 11;
   localparam int DEFAULT_ADDER      = 170;
   localparam int DEFAULT_OVERSAMPLE = 16;
   localparam int DEFAULT_STOP_BITS  = 1;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud accumulator; o_tick is the combinational carry-out of acc + ADDER.
// Latency: tick asserted in the cycle whose edge wraps the accumulator.
// Backpressure: none; i_clear zeroes the phase, i_enable gates advancement.
module uart_baud_tick
   import uart_transmitter_pkg::*;
#(
   parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH,
   parameter int ADDER     = DEFAULT_ADDER
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   // One extra bit so ADDER == 2^BIT_DEPTH is representable (tick every cycle).
   localparam logic [BIT_DEPTH:0] ADD_VALUE = (BIT_DEPTH + 1)'(ADDER);

   logic [BIT_DEPTH-1:0] acc;
   logic [BIT_DEPTH:0]   sum;

   assign sum    = {1'b0, acc} + ADD_VALUE;
   assign o_tick = i_enable & ~i_clear & sum[BIT_DEPTH];

   // Phase accumulator: clear wins, otherwise advance only while enabled.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         acc <= '0;
      end else if (i_clear) begin
         acc <= '0;
      end else if (i_enable) begin
         acc <= sum[BIT_DEPTH-1:0];
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit: start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop bit(s).
// Latency: o_tx falls one clock after accept; each bit lasts OVERSAMPLE baud ticks.
// Backpressure: o_ready high only in IDLE; i_data_valid ignored while busy.
module uart_transmitter
   import uart_transmitter_pkg::*;
#(
   parameter int BIT_DEPTH  = DEFAULT_BIT_DEPTH,
   parameter int ADDER      = DEFAULT_ADDER,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int STOP_BITS  = DEFAULT_STOP_BITS
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_8_data,
   input  logic       i_data_valid,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_done
);

   localparam int              CNT_W     = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

   uart_state_t      state;
   logic [7:0]       shift_reg;
   logic [2:0]       bit_idx;
   logic [CNT_W-1:0] tick_cnt;
   logic             tick;
   logic             accept;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   assign accept  = o_ready & i_data_valid;
   assign bit_end = tick & (tick_cnt == TICK_LAST);

   uart_baud_tick #(
      .BIT_DEPTH (BIT_DEPTH),
      .ADDER     (ADDER)
   ) u_baud_tick (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (accept),
      .i_enable (state != ST_IDLE),
      .o_tick   (tick)
   );

   // Ticks within the current bit; restarted on accept so every bit is OVERSAMPLE ticks.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         tick_cnt <= '0;
      end else if (accept) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end
   end

   // Frame sequencer; o_tx reflects the state held before each edge, hence the one-clock lag.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         o_tx       <= IDLE_LEVEL;
         o_ready    <= 1'b1;
         o_done     <= 1'b0;
         shift_reg  <= '0;
         bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         o_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_tx <= IDLE_LEVEL;
               if (accept) begin
                  shift_reg  <= i_8_data;
                  bit_idx    <= '0;
                  o_ready    <= 1'b0;
                  state      <= ST_START;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= even_parity(i_8_data);
`endif
               end
            end
            ST_START: begin
               o_tx <= START_BIT;
               if (bit_end) begin
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               o_tx <= shift_reg[0];
               if (bit_end) begin
                  shift_reg <= {1'b0, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= ST_PARITY;
`else
                     state   <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               o_tx <= parity_bit;
               if (bit_end) begin
                  bit_idx <= '0;
                  state   <= ST_STOP;
               end
            end
`endif
            ST_STOP: begin
               o_tx <= STOP_BIT;
               if (bit_end) begin
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     o_done  <= 1'b1;
                     o_ready <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            default: begin
               o_tx    <= IDLE_LEVEL;
               o_ready <= 1'b1;
               bit_idx <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: every cycle of each frame compared to a bit-list model.
// Latency: ADDER=1024, OVERSAMPLE=16 -> 32 clocks per bit.
// Backpressure: bench waits on o_ready with a bounded cycle budget.
module tb_uart_transmitter;

   localparam int CLK_PER_BIT = 32;
   localparam int STOPS       = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_line;
   logic       tx_done;

   int total = 0;
   int bad   = 0;

   logic exp_bits [0:15];
   int   exp_n;

   always #5 clk = ~clk;

   uart_transmitter #(
      .BIT_DEPTH  (11),
      .ADDER      (1024),
      .OVERSAMPLE (16),
      .STOP_BITS  (STOPS)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_8_data     (tx_data),
      .i_data_valid (tx_valid),
      .o_ready      (tx_ready),
      .o_tx         (tx_line),
      .o_done       (tx_done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Serial frame as a plain list of line levels, one per bit period.
   task automatic build_frame(input logic [7:0] d);
      int ones;
      int b;
      ones  = 0;
      exp_n = 0;
      exp_bits[exp_n] = 1'b0;
      exp_n++;
      for (int i = 0; i < 8; i++) begin
         b = (int'(d) >> i) % 2;
         ones += b;
         exp_bits[exp_n] = (b == 1);
         exp_n++;
      end
      for (int i = 0; i < PAR_BITS; i++) begin
         exp_bits[exp_n] = ((ones % 2) == 1);
         exp_n++;
      end
      for (int i = 0; i < STOPS; i++) begin
         exp_bits[exp_n] = 1'b1;
         exp_n++;
      end
   endtask

   task automatic wait_ready(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (tx_ready === 1'b1) ok = 1'b1;
         else step();
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s ready_timeout: o_ready=%b after 2000 cycles, wanted 1", name, tx_ready);
      end
   endtask

   // Called #1 after the accept edge; walks the whole frame cycle by cycle.
   task automatic check_frame(input logic [7:0] d, input string name);
      int   last;
      logic e_tx;
      logic e_end;
      build_frame(d);
      last = exp_n * CLK_PER_BIT;
      total += 3;
      if (tx_ready !== 1'b0) begin
         bad++;
         $display("FAIL %s accept_ready: got %b want 0", name, tx_ready);
      end
      if (tx_line !== 1'b1) begin
         bad++;
         $display("FAIL %s accept_tx: got %b want 1", name, tx_line);
      end
      if (tx_done !== 1'b0) begin
         bad++;
         $display("FAIL %s accept_done: got %b want 0", name, tx_done);
      end
      for (int c = 1; c <= last; c++) begin
         step();
         e_tx  = exp_bits[(c - 1) / CLK_PER_BIT];
         e_end = (c == last);
         total += 3;
         if (tx_line !== e_tx) begin
            bad++;
            $display("FAIL %s tx c=%0d: got %b want %b (data %h)", name, c, tx_line, e_tx, d);
         end
         if (tx_done !== e_end) begin
            bad++;
            $display("FAIL %s done c=%0d: got %b want %b", name, c, tx_done, e_end);
         end
         if (tx_ready !== e_end) begin
            bad++;
            $display("FAIL %s ready c=%0d: got %b want %b", name, c, tx_ready, e_end);
         end
      end
   endtask

   task automatic send(input logic [7:0] d, input string name);
      wait_ready(name);
      tx_data  = d;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      check_frame(d, name);
   endtask

   task automatic test_reset();
      bit quiet;
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      step();
      step();
      total += 3;
      if (tx_line !== 1'b1) begin
         bad++;
         $display("FAIL reset_tx: got %b want 1", tx_line);
      end
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_ready: got %b want 1", tx_ready);
      end
      if (tx_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_done: got %b want 0", tx_done);
      end
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 500; i++) begin
         step();
         if (tx_line !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1) quiet = 1'b0;
      end
      total++;
      if (!quiet) begin
         bad++;
         $display("FAIL reset_idle_500: outputs moved, now tx=%b done=%b ready=%b want 1/0/1",
                  tx_line, tx_done, tx_ready);
      end
   endtask

   task automatic test_single();
      send(8'hA5, "single_a5");
   endtask

   task automatic test_back_to_back();
      wait_ready("b2b");
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      step();
      check_frame(8'h00, "b2b_first");
      tx_data = 8'hFF;
      step();
      tx_valid = 1'b0;
      check_frame(8'hFF, "b2b_second");
   endtask

   task automatic test_reset_mid_frame(input int data_bit);
      int target;
      wait_ready("midrst");
      build_frame(8'h3C);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      step();
      tx_valid = 1'b0;
      target = 1 + CLK_PER_BIT * (1 + data_bit) + CLK_PER_BIT / 2;
      for (int c = 1; c <= target; c++) step();
      total++;
      if (tx_line !== exp_bits[1 + data_bit]) begin
         bad++;
         $display("FAIL midrst_pre bit%0d: got %b want %b", data_bit, tx_line, exp_bits[1 + data_bit]);
      end
      #2 rst_n = 1'b0;
      #1;
      total += 3;
      if (tx_line !== 1'b1) begin
         bad++;
         $display("FAIL midrst_tx bit%0d: got %b want 1", data_bit, tx_line);
      end
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_ready bit%0d: got %b want 1", data_bit, tx_ready);
      end
      if (tx_done !== 1'b0) begin
         bad++;
         $display("FAIL midrst_done bit%0d: got %b want 0", data_bit, tx_done);
      end
      step();
      step();
      rst_n = 1'b1;
      send(8'h81, "after_midrst_81");
   endtask

   task automatic test_release_with_valid();
      rst_n    = 1'b0;
      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      tx_valid = 1'b0;
      check_frame(8'h5A, "release_valid_5a");
   endtask

   task automatic test_random();
      logic [7:0] d;
      int         gap;
      bit         idle_ok;
      for (int n = 0; n < 30; n++) begin
         gap     = $urandom_range(0, 5);
         idle_ok = 1'b1;
         for (int g = 0; g < gap; g++) begin
            step();
            if (tx_line !== 1'b1 || tx_ready !== 1'b1) idle_ok = 1'b0;
         end
         total++;
         if (!idle_ok) begin
            bad++;
            $display("FAIL random_gap n=%0d: tx=%b ready=%b want 1/1", n, tx_line, tx_ready);
         end
         d = 8'($urandom_range(0, 255));
         send(d, "random");
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      send(8'h07, "parity_07");
      send(8'h03, "parity_03");
   endtask
`endif

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid_frame(4);
      test_reset_mid_frame(0);
      test_release_with_valid();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
